arith_pipe: RTL and testbench
=============================

ARITH_PIPE -- requirements
Module: arith_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand/result width (2..32).
REQ-002 The block SHALL have parameter ACC_WIDTH, default 16, meaning accumulator width (>= WIDTH+1).
REQ-003 The block SHALL have parameter DEPTH, default 2, meaning result buffer entries (power of two, 2..8).
REQ-004 clk  input  1  clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  operand beat valid.
REQ-007 in_ready  output  1  block can accept a beat.
REQ-008 op_a, op_b  input  WIDTH each  operands, unsigned.
REQ-009 mode  input  2  operation select (mode_e).
REQ-010 clr_acc  input  1  synchronous accumulator clear.
REQ-011 out_valid  output  1  result buffer non-empty.
REQ-012 out_ready  input  1  consumer takes the head result.
REQ-013 result  output  WIDTH  head result.
REQ-014 flag  output  1  head carry/borrow/saturation/overflow flag.
REQ-015 acc  output  ACC_WIDTH  current accumulator value.
REQ-016 beat_count  output  16  accepted-beat counter, wraps 0xFFFF->0.

Function
REQ-017 Accept SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-018 in_ready SHALL equal (count < DEPTH), derived from registered state only; no combinational path from out_ready or in_valid.
REQ-019 Modes, all SHALL compute from accept-cycle operands: ADD=0 result=(a+b) mod 2^WIDTH, flag=carry out; SUB=1 result=(a-b) mod 2^WIDTH, flag=borrow (a<b); SAT=2 result=min(a+b, 2^WIDTH-1), flag=1 iff clipped; ACC=3 acc<=acc+a+b (zero-extended, mod 2^ACC_WIDTH), result=new acc[WIDTH-1:0], flag=carry out of ACC_WIDTH.
REQ-020 Latency SHALL be 1: a beat accepted at edge N into an empty buffer SHALL present out_valid/result/flag from edge N onward.
REQ-021 Results SHALL leave in acceptance order; head SHALL hold stable while out_valid && !out_ready.
REQ-022 Simultaneous accept and pop SHALL leave count unchanged and be legal at any count < DEPTH.
REQ-023 When count == DEPTH, in_ready SHALL be 0 even if out_ready=1 that cycle; it SHALL rise the cycle after the pop.
REQ-024 Read/write pointers SHALL wrap modulo DEPTH without losing or duplicating entries.
REQ-025 acc SHALL change only on ACC-mode accept or clr_acc; non-ACC modes SHALL not alter acc.
REQ-026 clr_acc alone SHALL set acc to 0 next edge; clr_acc with an ACC-mode accept SHALL set acc to a+b (clear first, then add), result/flag from that value.
REQ-027 beat_count SHALL increment by 1 per accept, independent of mode.

Reset
REQ-028 With rst_n low at an edge: count, pointers, acc, beat_count SHALL become 0; out_valid=0; in_ready=1 after that edge; result/flag SHALL read 0.
REQ-029 Reset mid-operation SHALL discard all buffered results; no pop SHALL be reported for them; reset SHALL dominate accept, pop and clr_acc in the same cycle.

Structure
REQ-030 Package arith_pkg SHALL hold mode_e (ADD, SUB, SAT, ACC), default WIDTH/ACC_WIDTH/DEPTH constants, and the buffer entry struct {result, flag}.
REQ-031 The buffer SHALL be sub-module result_fifo (parametrised DEPTH and entry type, show-ahead head, count output); arith_pipe SHALL hold operation logic, acc and beat_count.

Verification
REQ-032 ADD a=0xF0 b=0x20 -> result=0x10 flag=1 one cycle later; SUB a=0x05 b=0x07 -> result=0xFE flag=1.
REQ-033 SAT a=0xC8 b=0x64 -> result=0xFF flag=1; SAT a=0x10 b=0x20 -> result=0x30 flag=0.
REQ-034 ACC from 0: beats (0xFF,0xFF)x3 -> acc=0x01FE,0x03FC,0x05FA, result=0xFE,0xFC,0xFA; then clr_acc with ACC (0x01,0x02) -> acc=0x0003.
REQ-035 out_ready=0, stream 3 beats: two accepted, in_ready=0 after second; raise out_ready -> in_ready rises one cycle after first pop; all 3 results emerge in order.
REQ-036 Continuous in_valid=out_ready=1 for 20 beats -> one result per cycle, count stays 1, beat_count=20, pointer wrap clean.
REQ-037 Assert rst_n=0 with 2 results buffered and acc=0x1234 -> next cycle out_valid=0, acc=0, beat_count=0, in_ready=1.

Source files
------------

// File: rtl/arith_pkg.sv
// arith_pkg: shared types and defaults for the arith_pipe block.
//   mode_e        : operation select (ADD, SUB, SAT, ACC)
//   DEF_*         : default WIDTH / ACC_WIDTH / DEPTH
//   entry_t       : result buffer entry {result, flag} at the default width
package arith_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_ACC_WIDTH = 16;
    localparam int DEF_DEPTH     = 2;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        SAT = 2'd2,
        ACC = 2'd3
    } mode_e;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] result;
        logic                 flag;
    } entry_t;

endpackage

// File: rtl/result_fifo.sv
// result_fifo: show-ahead FIFO of DEPTH entries (DEPTH a power of two).
//   clk, rst_n  : clock, synchronous active-low reset
//   push        : write push_data at the tail (ignored when full)
//   push_data   : entry to write
//   pop         : drop the head entry (ignored when empty)
//   head        : current head entry, reads '0 while empty
//   count       : number of stored entries (0..DEPTH)
module result_fifo #(
    parameter int  DEPTH   = arith_pkg::DEF_DEPTH,
    parameter type entry_t = arith_pkg::entry_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    entry_t          mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && (count < (PW+1)'(DEPTH));
    assign do_pop  = pop && (count != '0);

    // Pointers are exactly PW bits wide, so the +1 wraps modulo DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/arith_pipe.sv
// arith_pipe: one-beat arithmetic unit (ADD/SUB/SAT/ACC) feeding a result FIFO.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : operand beat handshake
//   op_a, op_b, mode     : unsigned operands and operation select
//   clr_acc              : clear accumulator (applied before an ACC add)
//   out_valid / out_ready: result handshake, head of the FIFO
//   result, flag         : head result and its carry/borrow/clip flag
//   acc                  : accumulator value
//   beat_count           : accepted beats, wraps at 16 bits
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high; the producer holds its data until then. in_ready depends on the
// stored count only, so a full buffer stays not-ready in the cycle of a pop.
module arith_pipe
    import arith_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int DEPTH     = DEF_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    input  mode_e                mode,
    input  logic                 clr_acc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic                 flag,
    output logic [ACC_WIDTH-1:0] acc,
    output logic [15:0]          beat_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             flag;
    } pipe_entry_t;

    logic [CW-1:0]      count;
    logic               accept;
    logic               pop;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [ACC_WIDTH-1:0] acc_base;
    logic [ACC_WIDTH:0] acc_sum;
    pipe_entry_t        new_entry;
    pipe_entry_t        head;

    assign in_ready  = (count < CW'(DEPTH));
    assign out_valid = (count != '0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // One extra bit catches carry (add) and borrow (subtract).
    assign sum  = {1'b0, op_a} + {1'b0, op_b};
    assign diff = {1'b0, op_a} - {1'b0, op_b};

    // clr_acc together with an ACC beat clears first, then adds.
    assign acc_base = clr_acc ? '0 : acc;
    assign acc_sum  = {1'b0, acc_base} + {{(ACC_WIDTH-WIDTH){1'b0}}, sum};

    always_comb begin
        new_entry.result = sum[WIDTH-1:0];
        new_entry.flag   = sum[WIDTH];
        case (mode)
            ADD: begin
                new_entry.result = sum[WIDTH-1:0];
                new_entry.flag   = sum[WIDTH];
            end
            SUB: begin
                new_entry.result = diff[WIDTH-1:0];
                new_entry.flag   = diff[WIDTH];
            end
            SAT: begin
                new_entry.result = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
                new_entry.flag   = sum[WIDTH];
            end
            ACC: begin
                new_entry.result = acc_sum[WIDTH-1:0];
                new_entry.flag   = acc_sum[ACC_WIDTH];
            end
            default: begin
                new_entry.result = sum[WIDTH-1:0];
                new_entry.flag   = sum[WIDTH];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc        <= '0;
            beat_count <= '0;
        end else begin
            if (accept && (mode == ACC)) acc <= acc_sum[ACC_WIDTH-1:0];
            else if (clr_acc)            acc <= '0;
            if (accept) beat_count <= beat_count + 16'd1;
        end
    end

    result_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (pipe_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (accept),
        .push_data (new_entry),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign result = head.result;
    assign flag   = head.flag;

endmodule

// File: tb/tb_arith_pipe.sv
module tb_arith_pipe;
    import arith_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    mode_e       mode;
    logic        clr_acc;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  result;
    logic        flag;
    logic [15:0] acc;
    logic [15:0] beat_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    arith_pipe #(.WIDTH(8), .ACC_WIDTH(16), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .mode       (mode),
        .clr_acc    (clr_acc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flag       (flag),
        .acc        (acc),
        .beat_count (beat_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one edge, then settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // one beat into an empty buffer, check head, then pop it
    task automatic do_one(input string tag, input mode_e m, input logic [7:0] a,
                          input logic [7:0] b, input logic clr,
                          input logic [7:0] exp_res, input logic exp_flag,
                          input logic [15:0] exp_acc);
        in_valid  = 1'b1;
        mode      = m;
        op_a      = a;
        op_b      = b;
        clr_acc   = clr;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        clr_acc  = 1'b0;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_result"}, 32'(result), 32'(exp_res));
        check({tag, "_flag"}, 32'(flag), 32'(exp_flag));
        check({tag, "_acc"}, 32'(acc), 32'(exp_acc));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_empty"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] a_v;
        logic [7:0] b_v;
        logic [7:0] e_v;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        mode      = ADD;
        clr_acc   = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flag", 32'(flag), 32'd0);
        check("rst_acc", 32'(acc), 32'd0);
        check("rst_beats", 32'(beat_count), 32'd0);

        // basic modes
        do_one("add_carry", ADD, 8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, 16'h0000);
        do_one("sub_borrow", SUB, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b1, 16'h0000);
        do_one("sat_clip", SAT, 8'hC8, 8'h64, 1'b0, 8'hFF, 1'b1, 16'h0000);
        do_one("sat_noclip", SAT, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 16'h0000);

        // accumulate
        do_one("acc1", ACC, 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b0, 16'h01FE);
        do_one("acc2", ACC, 8'hFF, 8'hFF, 1'b0, 8'hFC, 1'b0, 16'h03FC);
        do_one("acc3", ACC, 8'hFF, 8'hFF, 1'b0, 8'hFA, 1'b0, 16'h05FA);
        do_one("add_keeps_acc", ADD, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 16'h05FA);
        do_one("acc_clr_add", ACC, 8'h01, 8'h02, 1'b1, 8'h03, 1'b0, 16'h0003);
        clr_acc = 1'b1;
        step();
        clr_acc = 1'b0;
        check("clr_only_acc", 32'(acc), 32'd0);
        check("beats_9", 32'(beat_count), 32'd9);

        // backpressure: 3 beats, consumer stalled
        mode = ADD; out_ready = 1'b0; in_valid = 1'b1;
        op_a = 8'd1; op_b = 8'd1;
        step();
        op_a = 8'd2; op_b = 8'd2;
        step();
        op_a = 8'd3; op_b = 8'd3;
        check("bp_full_ready", 32'(in_ready), 32'd0);
        check("bp_head0", 32'(result), 32'd2);
        step();
        check("bp_stall_ready", 32'(in_ready), 32'd0);
        check("bp_stall_head", 32'(result), 32'd2);
        out_ready = 1'b1;
        step();
        check("bp_ready_rise", 32'(in_ready), 32'd1);
        check("bp_head1", 32'(result), 32'd4);
        step();
        in_valid = 1'b0;
        check("bp_head2", 32'(result), 32'd6);
        check("bp_head2_valid", 32'(out_valid), 32'd1);
        step();
        check("bp_drained", 32'(out_valid), 32'd0);
        check("beats_12", 32'(beat_count), 32'd12);

        // streaming: one result per cycle through the wrapping pointers
        in_valid = 1'b1; out_ready = 1'b1; mode = ADD;
        for (int i = 0; i < 20; i++) begin
            a_v = 8'(i * 7 + 3);
            b_v = 8'(i * 13);
            op_a = a_v;
            op_b = b_v;
            e_v = a_v + b_v;
            exp_q.push_back(e_v);
            step();
            e_v = exp_q.pop_front();
            check($sformatf("stream_res_%0d", i), 32'(result), 32'(e_v));
            check($sformatf("stream_ready_%0d", i), 32'(in_ready), 32'd1);
        end
        in_valid = 1'b0;
        step();
        check("stream_drained", 32'(out_valid), 32'd0);
        check("beats_32", 32'(beat_count), 32'd32);

        // build acc = 0x1234 : 9 x 0x1FE + 0x46
        in_valid = 1'b1; out_ready = 1'b1; mode = ACC;
        op_a = 8'hFF; op_b = 8'hFF;
        for (int i = 0; i < 9; i++) step();
        op_a = 8'h23; op_b = 8'h23;
        step();
        in_valid = 1'b0;
        check("acc_1234", 32'(acc), 32'h1234);
        check("acc_1234_res", 32'(result), 32'h34);
        step();

        // two results buffered, then reset with every other input active
        out_ready = 1'b0; in_valid = 1'b1; mode = ADD;
        op_a = 8'd1; op_b = 8'd1;
        step();
        op_a = 8'd2; op_b = 8'd2;
        step();
        in_valid = 1'b0;
        check("pre_rst_full", 32'(in_ready), 32'd0);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_beats", 32'(beat_count), 32'h2C);
        rst_n = 1'b0; in_valid = 1'b1; mode = ACC; op_a = 8'd5; op_b = 8'd5;
        clr_acc = 1'b1; out_ready = 1'b1;
        step();
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_acc", 32'(acc), 32'd0);
        check("mid_rst_beats", 32'(beat_count), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_result", 32'(result), 32'd0);
        rst_n = 1'b1; in_valid = 1'b0; clr_acc = 1'b0;
        step();
        check("post_rst_valid", 32'(out_valid), 32'd0);
        check("post_rst_beats", 32'(beat_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
